colorflyx_uart_rx: RTL and testbench
====================================

# colorflyx_uart_rx

Serial command receiver for the colorflyx TinyTapeout user project. It sits directly upstream of the project core: it deserialises 8N1 UART frames arriving on a dedicated input pin and buffers the received bytes in a small show-ahead FIFO. The core consumes bytes via `rd_en`. Sticky error flags are exposed for routing to `uo_out`/`uio_out` debug bits.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be even and ≥ 4.
- `FIFO_DEPTH`, default 4: number of byte entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous reset, active-low; resets all state.
- `ena`  in  1  TinyTapeout design enable. While low, no new frame starts; the FIFO stays readable.
- `rx`  in  1  asynchronous serial input (from `ui_in[0]`); idle level is high.
- `rd_en`  in  1  pop the head entry; ignored when `rd_valid`=0.
- `clr_err`  in  1  synchronous clear of `frame_err` and `overrun`.
- `rd_data`  out  8  head FIFO entry (show-ahead); valid only when `rd_valid`=1.
- `rd_valid`  out  1  FIFO not empty.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `frame_err`  out  1  sticky; set when a stop bit is sampled as 0.
- `overrun`  out  1  sticky; set when a good byte arrives while the FIFO is full and is not popped that cycle.

## Operation
- Input synchroniser: 2 flops, both reset to 1. The FSM uses only the synchronised signal `rx_s`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: if `ena`=1 and `rx_s`=0, go to START and load the bit counter with `CLKS_PER_BIT/2-1`.
- START: at counter expiry, sample `rx_s`.
  - If 1 (glitch), return to IDLE.
  - If 0, go to DATA and reload the counter with `CLKS_PER_BIT-1`.
- DATA: sample 8 bits, LSB first, one at each counter expiry, then go to STOP.
- STOP: at counter expiry, sample `rx_s`.
  - If 1: push the byte to the FIFO, or set `overrun` and drop the byte. Return to IDLE.
  - If 0: set `frame_err`, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- `ena` falling mid-frame does not abort the frame; it only blocks the IDLE→START transition.
- FIFO:
  - Circular buffer with read and write pointers of `log2(FIFO_DEPTH)` bits, plus a count of `log2(FIFO_DEPTH)+1` bits.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Push when full is accepted only if `rd_en`=1 in the same cycle (pop-then-push). The count is unchanged.
  - Push and pop together when not full: count unchanged, both pointers advance.
  - Pop when empty: no effect.
- `clr_err` and a new error event in the same cycle: the set wins, so the flag stays 1.

## Timing
- All outputs are registered or derived from registers. No combinational path exists from `rx` or `rd_en` to any output.
- Reset values:
  - FSM = IDLE; synchroniser = 1; FIFO pointers and count = 0.
  - `rd_valid`=0, `fifo_full`=0, `frame_err`=0, `overrun`=0, `rd_data`=0.
- Latency, with t0 = first cycle `rx_s`=0 (the `rx` pin falls 2 cycles earlier):
  - Start mid-sample at t0+`CLKS_PER_BIT/2`.
  - Data bit i sampled at t0+`CLKS_PER_BIT/2`+(i+1)·`CLKS_PER_BIT`.
  - Stop sampled at t0+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
  - `rd_valid` and `rd_data` update the next cycle. With the default: stop at t0+152, byte visible at t0+153.
- `rd_en` pop: the next entry (or `rd_valid`=0) appears the cycle after `rd_en` is sampled high.
- Back-to-back frames: a start edge one cycle after the STOP→IDLE transition must be accepted.
- The error flags assert in the cycle after the offending stop sample and clear the cycle after `clr_err`.
- Reset mid-frame: the FSM returns to IDLE immediately (asynchronously), the FIFO empties, and the partial byte is lost.

## Test plan
- **Single byte:** send 0xA5 at 16 clks/bit with `ena`=1.
  - `rd_valid` rises 153 cycles after `rx_s` falls.
  - `rd_data`=0xA5.
  - Pulse `rd_en` → `rd_valid`=0 next cycle.
- **Fill and overrun:** send 0x01..0x05 with no reads.
  - `fifo_full`=1 after 0x04.
  - `overrun`=1 after 0x05.
  - Reads return 0x01,0x02,0x03,0x04.
  - `clr_err` → `overrun`=0.
- **Framing error:** send 0x3C with stop bit 0, then hold `rx` low for 40 bit-times, then release and send 0x7E.
  - `frame_err`=1.
  - No byte pushed for 0x3C, and none during the break.
  - 0x7E is received correctly.
- **Glitch rejection:** drive `rx` low for 4 cycles in IDLE.
  - FSM returns to IDLE.
  - No byte is pushed and no flag is set.
- **Simultaneous push/pop when full:** with 4 entries held, assert `rd_en` in the cycle the 5th stop bit is accepted.
  - No overrun.
  - `fifo_full` stays 1.
  - Subsequent read order is intact, including pointer wrap.
- **Reset and `ena`:**
  - Assert `rst_n`=0 mid-DATA → all outputs at reset values within the same cycle; the following frame is received correctly.
  - Hold `ena`=0 during a start edge → no reception.

Source files
------------

// File: rtl/colorflyx_uart_rx.sv
// 8N1 UART receiver with a show-ahead byte FIFO and sticky error flags.
// Bit timing is counted from a two-flop synchronised copy of the rx pin.
module colorflyx_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          good_byte, bad_stop, tick;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, push, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
        end
    end

    assign tick = (cnt == '0);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_n     = bit_idx;
        sh_n      = shreg;
        good_byte = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (ena && !rx_s) begin
                    state_n = START;
                    cnt_n   = HALF_M1;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = DATA;
                    cnt_n   = FULL_M1;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    sh_n  = {rx_s, shreg[7:1]};
                    cnt_n = FULL_M1;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s) begin
                    good_byte = 1'b1;
                    state_n   = IDLE;
                end else begin
                    bad_stop = 1'b1;
                    state_n  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // a held-low line (break) must not look like back-to-back frames
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A push into a full FIFO only lands when the head is popped in the same cycle.
    assign full = (count == DEPTH_C);
    assign pop  = rd_en && (count != '0);
    assign push = good_byte && (!full || rd_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (bad_stop)     frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (good_byte && full && !rd_en) overrun <= 1'b1;
            else if (clr_err)                overrun <= 1'b0;
        end
    end

    assign rd_data   = mem[rd_ptr];
    assign rd_valid  = (count != '0);
    assign fifo_full = full;
endmodule

// File: tb/tb_colorflyx_uart_rx.sv
// Directed bench for colorflyx_uart_rx at 16 clocks/bit, 4-entry FIFO.
module tb_colorflyx_uart_rx;
    logic       clk, rst_n, ena, rx, rd_en, clr_err;
    logic [7:0] rd_data;
    logic       rd_valid, fifo_full, frame_err, overrun;
    int         tests, fails, rise_at;

    colorflyx_uart_rx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_full(fifo_full), .frame_err(frame_err), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one 160-cycle frame starting at a negedge; rise_at counts negedges
    // from the pin falling to rd_valid first rising. pop_at >= 0 pulses rd_en.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at);
        logic was;
        was = rd_valid;
        rise_at = -1;
        for (int i = 0; i < 160; i++) begin
            if (i < 16)       rx = 1'b0;
            else if (i < 144) rx = b[(i - 16) / 16];
            else              rx = stop;
            if (pop_at >= 0) rd_en = (i == pop_at);
            @(negedge clk);
            if (!was && rd_valid && rise_at < 0) rise_at = i + 1;
        end
        if (pop_at >= 0) rd_en = 1'b0;
    endtask

    task automatic pop_one;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if ({rd_valid, fifo_full, frame_err, overrun, rd_data} !== 12'h000) begin
            fails++;
            $display("FAIL reset_vals got v=%b f=%b fe=%b ov=%b d=%h want all 0",
                     rd_valid, fifo_full, frame_err, overrun, rd_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_valid got %b want 0", rd_valid);
        end
    endtask

    task automatic test_single;
        send_frame(8'hA5, 1'b1, -1);
        tests++;
        if (rise_at != 155) begin  // 2 sync cycles + 153 from rx_s fall
            fails++;
            $display("FAIL single_latency got %0d want 155", rise_at);
        end
        tests++;
        if (rd_data !== 8'hA5) begin
            fails++;
            $display("FAIL single_data got %h want a5", rd_data);
        end
        pop_one();
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_pop got %b want 0", rd_valid);
        end
        pop_one();
        tests++;
        if (rd_valid !== 1'b0 || fifo_full !== 1'b0) begin
            fails++;
            $display("FAIL pop_empty got v=%b f=%b want 0 0", rd_valid, fifo_full);
        end
    endtask

    task automatic test_fill_overrun;
        logic [7:0] exp;
        for (int k = 1; k <= 3; k++) send_frame(8'(k), 1'b1, -1);
        tests++;
        if (fifo_full !== 1'b0) begin
            fails++;
            $display("FAIL full_after3 got %b want 0", fifo_full);
        end
        send_frame(8'h04, 1'b1, -1);
        tests++;
        if (fifo_full !== 1'b1 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL full_after4 got f=%b ov=%b want 1 0", fifo_full, overrun);
        end
        send_frame(8'h05, 1'b1, -1);
        tests++;
        if (overrun !== 1'b1 || fifo_full !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set got ov=%b f=%b want 1 1", overrun, fifo_full);
        end
        for (int k = 1; k <= 4; k++) begin
            exp = 8'(k);
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                fails++;
                $display("FAIL fill_read%0d got v=%b d=%h want 1 %h", k, rd_valid, rd_data, exp);
            end
            pop_one();
        end
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL fill_drained got %b want 0", rd_valid);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clr got %b want 0", overrun);
        end
    endtask

    task automatic test_framing;
        send_frame(8'h3C, 1'b0, -1);
        repeat (640) @(negedge clk);
        tests++;
        if (frame_err !== 1'b1 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL frame_err got fe=%b v=%b want 1 0", frame_err, rd_valid);
        end
        idle(20);
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL break_push got %b want 0", rd_valid);
        end
        send_frame(8'h7E, 1'b1, -1);
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h7E) begin
            fails++;
            $display("FAIL after_break got v=%b d=%h want 1 7e", rd_valid, rd_data);
        end
        pop_one();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        tests++;
        if (frame_err !== 1'b0) begin
            fails++;
            $display("FAIL frame_clr got %b want 0", frame_err);
        end
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        tests++;
        if (rd_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL glitch got v=%b fe=%b ov=%b want 0 0 0", rd_valid, frame_err, overrun);
        end
        send_frame(8'h5A, 1'b1, -1);
        tests++;
        if (rd_data !== 8'h5A || rd_valid !== 1'b1) begin
            fails++;
            $display("FAIL glitch_recover got v=%b d=%h want 1 5a", rd_valid, rd_data);
        end
        pop_one();
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        for (int k = 0; k < 4; k++) send_frame(8'h10 + 8'(k), 1'b1, -1);
        // rd_en lands on the edge where the 5th stop bit is accepted
        send_frame(8'h14, 1'b1, 154);
        tests++;
        if (overrun !== 1'b0 || fifo_full !== 1'b1) begin
            fails++;
            $display("FAIL pushpop_full got ov=%b f=%b want 0 1", overrun, fifo_full);
        end
        for (int k = 1; k <= 4; k++) begin
            exp = 8'h10 + 8'(k);
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                fails++;
                $display("FAIL wrap_read%0d got v=%b d=%h want 1 %h", k, rd_valid, rd_data, exp);
            end
            pop_one();
        end
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_drained got %b want 0", rd_valid);
        end
    endtask

    task automatic test_reset_ena;
        send_frame(8'h99, 1'b1, -1);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({rd_valid, fifo_full, frame_err, overrun, rd_data} !== 12'h000) begin
            fails++;
            $display("FAIL midframe_reset got v=%b f=%b fe=%b ov=%b d=%h want all 0",
                     rd_valid, fifo_full, frame_err, overrun, rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        send_frame(8'hC3, 1'b1, -1);
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin
            fails++;
            $display("FAIL post_reset_rx got v=%b d=%h want 1 c3", rd_valid, rd_data);
        end
        pop_one();
        ena = 1'b0;
        send_frame(8'h77, 1'b1, -1);
        idle(20);
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL ena_low got %b want 0", rd_valid);
        end
        ena = 1'b1;
        idle(4);
        send_frame(8'h88, 1'b1, -1);
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h88) begin
            fails++;
            $display("FAIL ena_back got v=%b d=%h want 1 88", rd_valid, rd_data);
        end
        pop_one();
    endtask

    initial begin
        tests = 0; fails = 0; rise_at = -1;
        rst_n = 1'b0; ena = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        test_reset();
        test_single();
        test_fill_overrun();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_ena();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
